rhythm_counter: RTL and testbench

Parametrised successor to the single-shot clave counter. It counts enabled clock cycles from 0 to MAXCOUNT. At MAXCOUNT it either stops or wraps, depending on loop mode, for a bounded or unbounded number of loops. It also generates beat ticks at fixed subdivisions of the count, which drive the note/beat timing of a pattern track in the game datapath.

---
 rtl/rhythm_pkg.sv | 21 ++
 rtl/beat_divider.sv | 61 ++++++
 rtl/rhythm_counter.sv | 139 +++++++++++++
 tb/tb_rhythm_counter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm/pattern counters: FSM state encoding,
// the clave-track defaults and a small width helper.
package rhythm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Clave-track defaults: four beats of 1650 counts each.
    localparam int DEF_WIDTH    = 13;
    localparam int DEF_MAXCOUNT = 6600;
    localparam int DEF_BEAT_LEN = 1650;

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/beat_divider.sv
// Beat divider: a phase counter 0..BEAT_LEN-1 that follows the main count.
// clr restarts at a downbeat (phase 0, beat 0, tick asserted); adv steps the
// phase and enters the next beat when the phase wraps.
module beat_divider
    import rhythm_pkg::*;
#(
    parameter int BEAT_LEN = DEF_BEAT_LEN,
    parameter int BEAT_W   = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              adv,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              beat_tick
);

    localparam int                 PHASE_W    = clog2_min1(BEAT_LEN);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BEAT_LEN - 1);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [BEAT_W-1:0]  beat_idx_q, beat_idx_d;
    logic               beat_tick_q, beat_tick_d;

    // Next phase/beat: clear wins over advance; the tick lives for one cycle.
    always_comb begin
        phase_d     = phase_q;
        beat_idx_d  = beat_idx_q;
        beat_tick_d = 1'b0;
        if (clr) begin
            phase_d     = '0;
            beat_idx_d  = '0;
            beat_tick_d = 1'b1;
        end else if (adv) begin
            if (phase_q == PHASE_LAST) begin
                phase_d     = '0;
                beat_idx_d  = beat_idx_q + BEAT_W'(1);
                beat_tick_d = 1'b1;
            end else begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q     <= '0;
            beat_idx_q  <= '0;
            beat_tick_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            beat_idx_q  <= beat_idx_d;
            beat_tick_q <= beat_tick_d;
        end
    end

    assign beat_idx  = beat_idx_q;
    assign beat_tick = beat_tick_q;

endmodule

// File: rtl/rhythm_counter.sv
// Rhythm counter: counts enabled cycles 0..MAXCOUNT, then stops or wraps
// for a bounded/unbounded number of passes, with beat ticks from a divider.
module rhythm_counter
    import rhythm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAXCOUNT = DEF_MAXCOUNT,
    parameter int BEAT_LEN = DEF_BEAT_LEN,
    parameter int LOOPS_W  = 4,
    parameter int BEAT_W   = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic               en,
    input  logic               loop_mode,
    input  logic [LOOPS_W-1:0] loops_max,
    output logic [WIDTH-1:0]   count,
    output logic [BEAT_W-1:0]  beat_idx,
    output logic               beat_tick,
    output logic               wrap_tick,
    output logic               done,
    output logic               running,
    output logic [LOOPS_W-1:0] loop_cnt
);

    localparam logic [WIDTH-1:0]   MAX_C    = WIDTH'(MAXCOUNT);
    localparam logic [LOOPS_W-1:0] LOOP_SAT = '1;
    localparam logic [LOOPS_W:0]   ONE_EXT  = (LOOPS_W + 1)'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [LOOPS_W-1:0] loop_cnt_q, loop_cnt_d;
    logic               wrap_tick_q, wrap_tick_d;
    logic               done_q, done_d;
    logic               running_q, running_d;
    logic               div_clr, div_adv;
    logic               at_max, loop_ok;
    logic [LOOPS_W-1:0] loop_cnt_inc;

    // Decision terms for the terminal-count cycle; loop_cnt+1 is compared one
    // bit wider so it cannot overflow against loops_max.
    always_comb begin
        at_max       = (count_q >= MAX_C);
        loop_ok      = loop_mode &&
                       ((loops_max == '0) ||
                        (({1'b0, loop_cnt_q} + ONE_EXT) < {1'b0, loops_max}));
        loop_cnt_inc = (loop_cnt_q == LOOP_SAT) ? loop_cnt_q
                                                : loop_cnt_q + LOOPS_W'(1);
    end

    // FSM next state, count/loop updates, pulses and divider control.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        loop_cnt_d  = loop_cnt_q;
        wrap_tick_d = 1'b0;
        done_d      = 1'b0;
        div_clr     = 1'b0;
        div_adv     = 1'b0;
        if (go) begin
            state_d    = ST_COUNT;
            count_d    = '0;
            loop_cnt_d = '0;
            div_clr    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                end
                ST_COUNT: begin
                    if (en) begin
                        if (!at_max) begin
                            count_d = count_q + WIDTH'(1);
                            div_adv = 1'b1;
                        end else if (loop_ok) begin
                            count_d     = '0;
                            loop_cnt_d  = loop_cnt_inc;
                            wrap_tick_d = 1'b1;
                            div_clr     = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            if (loop_mode) begin
                                loop_cnt_d = loop_cnt_inc;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
        running_d = (state_d == ST_COUNT);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            loop_cnt_q  <= '0;
            wrap_tick_q <= 1'b0;
            done_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            loop_cnt_q  <= loop_cnt_d;
            wrap_tick_q <= wrap_tick_d;
            done_q      <= done_d;
            running_q   <= running_d;
        end
    end

    beat_divider #(
        .BEAT_LEN (BEAT_LEN),
        .BEAT_W   (BEAT_W)
    ) u_beat_divider (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (div_clr),
        .adv       (div_adv),
        .beat_idx  (beat_idx),
        .beat_tick (beat_tick)
    );

    assign count     = count_q;
    assign loop_cnt  = loop_cnt_q;
    assign wrap_tick = wrap_tick_q;
    assign done      = done_q;
    assign running   = running_q;

endmodule

// File: tb/tb_rhythm_counter.sv
// Directed bench for rhythm_counter with MAXCOUNT=9, BEAT_LEN=3, LOOPS_W=2.
module tb_rhythm_counter;

    localparam int WIDTH    = 4;
    localparam int MAXCOUNT = 9;
    localparam int BEAT_LEN = 3;
    localparam int LOOPS_W  = 2;
    localparam int BEAT_W   = 2;

    typedef struct {
        logic       go;
        logic       en;
        logic       lm;
        logic [1:0] lx;
        int         e_count;
        int         e_beat;
        logic       e_btick;
        logic       e_wtick;
        logic       e_done;
        logic       e_run;
        int         e_loop;
    } vec_t;

    logic               clk;
    logic               resetn;
    logic               go;
    logic               en;
    logic               loop_mode;
    logic [LOOPS_W-1:0] loops_max;
    logic [WIDTH-1:0]   count;
    logic [BEAT_W-1:0]  beat_idx;
    logic               beat_tick;
    logic               wrap_tick;
    logic               done;
    logic               running;
    logic [LOOPS_W-1:0] loop_cnt;

    int    checks = 0;
    int    errors = 0;
    int    row_no = 0;
    string ctx    = "";

    vec_t tbl [21];

    rhythm_counter #(
        .WIDTH    (WIDTH),
        .MAXCOUNT (MAXCOUNT),
        .BEAT_LEN (BEAT_LEN),
        .LOOPS_W  (LOOPS_W),
        .BEAT_W   (BEAT_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .go        (go),
        .en        (en),
        .loop_mode (loop_mode),
        .loops_max (loops_max),
        .count     (count),
        .beat_idx  (beat_idx),
        .beat_tick (beat_tick),
        .wrap_tick (wrap_tick),
        .done      (done),
        .running   (running),
        .loop_cnt  (loop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic g, input logic e, input logic lm,
                                input logic [1:0] lx, input int c, input int b,
                                input logic bt, input logic wt, input logic dn,
                                input logic rn, input int lc);
        vec_t v;
        v.go = g; v.en = e; v.lm = lm; v.lx = lx;
        v.e_count = c; v.e_beat = b; v.e_btick = bt; v.e_wtick = wt;
        v.e_done = dn; v.e_run = rn; v.e_loop = lc;
        return v;
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", ctx, nm, act, exp);
        end
    endtask

    task automatic check_outs(input vec_t v);
        cmp("count",     int'(count),     v.e_count);
        cmp("beat_idx",  int'(beat_idx),  v.e_beat);
        cmp("beat_tick", int'(beat_tick), int'(v.e_btick));
        cmp("wrap_tick", int'(wrap_tick), int'(v.e_wtick));
        cmp("done",      int'(done),      int'(v.e_done));
        cmp("running",   int'(running),   int'(v.e_run));
        cmp("loop_cnt",  int'(loop_cnt),  v.e_loop);
    endtask

    // Drive one cycle of inputs at the falling edge, check after the next rise.
    task automatic apply_row(input vec_t v);
        go = v.go; en = v.en; loop_mode = v.lm; loops_max = v.lx;
        @(negedge clk);
        ctx = $sformatf("row%0d", row_no);
        check_outs(v);
        $display("row%0d go=%0b en=%0b lm=%0b lx=%0d -> count=%0d beat=%0d bt=%0b wt=%0b done=%0b run=%0b loop=%0d",
                 row_no, v.go, v.en, v.lm, v.lx, count, beat_idx, beat_tick,
                 wrap_tick, done, running, loop_cnt);
        row_no++;
    endtask

    // Counts 1..n of a pass with en held high.
    task automatic run_steps(input int n, input int lc, input logic lm, input logic [1:0] lx);
        for (int i = 1; i <= n; i++) begin
            apply_row(mk(1'b0, 1'b1, lm, lx, i, i / BEAT_LEN,
                         (i % BEAT_LEN) == 0, 1'b0, 1'b0, 1'b1, lc));
        end
    endtask

    initial begin
        // Test 1: single pass, stop at MAXCOUNT.
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[1]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 1, 0, 0, 2, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(0, 1, 0, 0, 3, 1, 1, 0, 0, 1, 0);
        tbl[4]  = mk(0, 1, 0, 0, 4, 1, 0, 0, 0, 1, 0);
        tbl[5]  = mk(0, 1, 0, 0, 5, 1, 0, 0, 0, 1, 0);
        tbl[6]  = mk(0, 1, 0, 0, 6, 2, 1, 0, 0, 1, 0);
        tbl[7]  = mk(0, 1, 0, 0, 7, 2, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 1, 0, 0, 8, 2, 0, 0, 0, 1, 0);
        tbl[9]  = mk(0, 1, 0, 0, 9, 3, 1, 0, 0, 1, 0);
        tbl[10] = mk(0, 1, 0, 0, 9, 3, 0, 0, 1, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 9, 3, 0, 0, 0, 0, 0);
        // Test 2: restart from DONE with en low, then en 1,0,0,1 from count 4.
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[13] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[14] = mk(0, 1, 0, 0, 2, 0, 0, 0, 0, 1, 0);
        tbl[15] = mk(0, 1, 0, 0, 3, 1, 1, 0, 0, 1, 0);
        tbl[16] = mk(0, 1, 0, 0, 4, 1, 0, 0, 0, 1, 0);
        tbl[17] = mk(0, 1, 0, 0, 5, 1, 0, 0, 0, 1, 0);
        tbl[18] = mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0);
        tbl[20] = mk(0, 1, 0, 0, 6, 2, 1, 0, 0, 1, 0);

        resetn = 1'b0; go = 1'b0; en = 1'b0; loop_mode = 1'b0; loops_max = '0;
        repeat (2) @(negedge clk);
        ctx = "reset";
        check_outs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        resetn = 1'b1;

        // Idle with en high must not start counting.
        apply_row(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply_row(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < 21; k++) apply_row(tbl[k]);

        // Test 3: two bounded passes.
        apply_row(mk(1, 1, 1, 2, 0, 0, 1, 0, 0, 1, 0));
        run_steps(9, 0, 1'b1, 2'd2);
        apply_row(mk(0, 1, 1, 2, 0, 0, 1, 1, 0, 1, 1));
        run_steps(9, 1, 1'b1, 2'd2);
        apply_row(mk(0, 1, 1, 2, 9, 3, 0, 0, 1, 0, 2));
        apply_row(mk(0, 1, 1, 2, 9, 3, 0, 0, 0, 0, 2));

        // Test 4: unlimited looping, loop_cnt saturates at 3.
        apply_row(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        for (int p = 0; p < 5; p++) begin
            run_steps(9, sat3(p), 1'b1, 2'd0);
            apply_row(mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 1, sat3(p + 1)));
        end

        // Test 5: go at count 7 mid-run, then a single bounded pass and go in DONE.
        run_steps(7, 3, 1'b1, 2'd0);
        apply_row(mk(1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0));
        run_steps(9, 0, 1'b1, 2'd1);
        apply_row(mk(0, 1, 1, 1, 9, 3, 0, 0, 1, 0, 1));
        apply_row(mk(0, 1, 1, 1, 9, 3, 0, 0, 0, 0, 1));
        apply_row(mk(1, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0));

        // Test 6: asynchronous reset in the middle of a cycle at count 5.
        run_steps(5, 0, 1'b0, 2'd0);
        #2 resetn = 1'b0;
        #1;
        ctx = "async_reset";
        check_outs(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("async reset: count=%0d beat=%0d run=%0b loop=%0d", count, beat_idx, running, loop_cnt);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) apply_row(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply_row(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        apply_row(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
